// File: rtl/demux1_2_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer.
package Pkg_Global;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

endpackage

// File: rtl/demux1_2_out_slot.sv
// One-entry output register with valid/ready drain and a wrapping delivery counter.
// Latency 1 cycle load-to-valid; load is legal while FULL only in a draining cycle.
// No backpressure of its own: the parent gates load through in_ready.
module out_slot
  import Pkg_Global::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [N-1:0]  in_data,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt,
  output logic          full
);

  slot_state_e state, state_nxt;
  logic        drn;

  assign full      = (state == SLOT_FULL);
  assign out_valid = full;
  assign drn       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SLOT_EMPTY;
    else      state <= state_nxt;
  end

  // A drain and a load in the same cycle keep the slot FULL (pass-through).
  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (load)        state_nxt = SLOT_FULL;
      SLOT_FULL:  if (drn && !load) state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      out_data <= '0;
    else if (load) out_data <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (drn) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/demux1_2.sv
// Registered 1-to-2 stream demux: steers each accepted word to slot A or B by selector.
// Latency 1 cycle from acceptance to out_x_valid; 1 word/cycle sustained.
// in_ready drops only when the selected slot is FULL and its consumer is not ready.
module demux1_2
  import Pkg_Global::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          selector,
  output logic [N-1:0]  out_a,
  output logic          out_a_valid,
  input  logic          out_a_ready,
  output logic [N-1:0]  out_b,
  output logic          out_b_valid,
  input  logic          out_b_ready,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  logic a_full, b_full;
  logic acc, load_a, load_b;

  // Deliberately independent of in_valid so the producer sees a stable ready.
  assign in_ready = selector ? (!b_full | out_b_ready) : (!a_full | out_a_ready);
  assign acc      = in_valid & in_ready;
  assign load_a   = acc & !selector;
  assign load_b   = acc &  selector;

  out_slot #(.N(N), .CW(CW)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .in_data   (in_data),
    .out_data  (out_a),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .cnt       (cnt_a),
    .full      (a_full)
  );

  out_slot #(.N(N), .CW(CW)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .in_data   (in_data),
    .out_data  (out_b),
    .out_valid (out_b_valid),
    .out_ready (out_b_ready),
    .cnt       (cnt_b),
    .full      (b_full)
  );

endmodule

// File: tb/tb_demux1_2.sv
// Directed bench for demux1_2 (N=4, CW=8) with immediate-assertion checks.
module tb_demux1_2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       selector;
  logic [3:0] out_a;
  logic       out_a_valid;
  logic       out_a_ready;
  logic [3:0] out_b;
  logic       out_b_valid;
  logic       out_b_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int tests = 0;
  int fails = 0;

  demux1_2 #(.N(4), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .selector    (selector),
    .out_a       (out_a),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b       (out_b),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_a_valid", {31'b0, out_a_valid}, 0);
    chk("rst_b_valid", {31'b0, out_b_valid}, 0);
    chk("rst_out_a",   {28'b0, out_a}, 0);
    chk("rst_out_b",   {28'b0, out_b}, 0);
    chk("rst_cnt_a",   {24'b0, cnt_a}, 0);
    chk("rst_cnt_b",   {24'b0, cnt_b}, 0);
    chk("rst_in_ready",{31'b0, in_ready}, 1);
    #3 rst = 1'b1;
    tick();
  endtask

  logic [3:0] exp_a [2];
  logic [3:0] exp_b [2];
  int na, nb, idx, cyc;

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; selector = 1'b0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    tick();
    do_reset();

    // single steer to A
    in_data = 4'h5; selector = 1'b0; in_valid = 1'b1;
    #1 chk("steer_in_ready", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("steer_out_a",   {28'b0, out_a}, 5);
    chk("steer_a_valid", {31'b0, out_a_valid}, 1);
    chk("steer_b_valid", {31'b0, out_b_valid}, 0);
    out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
    chk("steer_cnt_a",   {24'b0, cnt_a}, 1);
    chk("steer_a_empty", {31'b0, out_a_valid}, 0);
    chk("steer_a_hold",  {28'b0, out_a}, 5);

    // backpressure on B, then redirect to A
    in_data = 4'h3; selector = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 4'h7;
    #1 chk("bp_in_ready", {31'b0, in_ready}, 0);
    tick();
    chk("bp_out_b_hold", {28'b0, out_b}, 3);
    chk("bp_b_valid",    {31'b0, out_b_valid}, 1);
    selector = 1'b0;
    #1 chk("bp_redirect_ready", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_out_a",    {28'b0, out_a}, 7);
    chk("bp_out_b",    {28'b0, out_b}, 3);
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    tick();
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    chk("bp_cnt_a", {24'b0, cnt_a}, 2);
    chk("bp_cnt_b", {24'b0, cnt_b}, 1);

    // reset mid-run with A holding 0xA
    in_data = 4'hA; selector = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_a_full", {31'b0, out_a_valid}, 1);
    do_reset();

    // pass-through stream 1..F on A
    out_a_ready = 1'b1; out_b_ready = 1'b1; selector = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      in_data = 4'(i);
      #1 chk("pt_in_ready", {31'b0, in_ready}, 1);
      tick();
      chk("pt_out_a", {28'b0, out_a}, i);
      chk("pt_cnt_a", {24'b0, cnt_a}, i - 1);
    end
    in_valid = 1'b0;
    tick();
    chk("pt_cnt_a_final", {24'b0, cnt_a}, 15);
    chk("pt_a_empty",     {31'b0, out_a_valid}, 0);

    // alternating selector with random readies
    exp_a[0] = 4'h1; exp_a[1] = 4'h3;
    exp_b[0] = 4'h2; exp_b[1] = 4'h4;
    na = 0; nb = 0; idx = 0; cyc = 0;
    while ((na + nb) < 4 && cyc < 200) begin
      in_valid    = (idx < 4);
      in_data     = 4'(idx + 1);
      selector    = idx[0];
      out_a_ready = 1'($urandom_range(0, 1));
      out_b_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_a_valid && out_a_ready) begin
        if (na < 2) chk("alt_a_word", {28'b0, out_a}, {28'b0, exp_a[na]});
        na++;
      end
      if (out_b_valid && out_b_ready) begin
        if (nb < 2) chk("alt_b_word", {28'b0, out_b}, {28'b0, exp_b[nb]});
        nb++;
      end
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_a_ready = 1'b0; out_b_ready = 1'b0;
    chk("alt_timeout",   (cyc < 200) ? 1 : 0, 1);
    chk("alt_na",        na, 2);
    chk("alt_nb",        nb, 2);
    chk("alt_sent",      idx, 4);
    #1;
    chk("alt_a_drained", {31'b0, out_a_valid}, 0);
    chk("alt_b_drained", {31'b0, out_b_valid}, 0);
    chk("alt_cnt_a",     {24'b0, cnt_a}, 17);
    chk("alt_cnt_b",     {24'b0, cnt_b}, 2);

    // counter wrap on B
    do_reset();
    out_b_ready = 1'b1; selector = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 4'(i);
      tick();
    end
    chk("wrap_cnt_b_255", {24'b0, cnt_b}, 255);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt_b_0",   {24'b0, cnt_b}, 0);
    chk("wrap_cnt_a",     {24'b0, cnt_a}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
